// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and helpers for the memory request arbiter: FSM encoding,
// bus size codes, the one-hot grant and the alignment rule.
package mem_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // One-hot grant; at most one field is set.
    typedef struct packed {
        logic data;
        logic inst;
    } grant_t;

    // The illegal size code 3 behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SIZE_W : size;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        logic mis;
        mis = 1'b0;
        case (norm_size(size))
            SIZE_H:  mis = addr_lo[0];
            SIZE_W:  mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_grant.sv
// Data-priority grant with a bounded-starvation guard for instruction fetch.
// The starve counter tracks consecutive data grants taken while fetch waits.
module mem_req_arbiter_grant
    import mem_req_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   inst_valid_i,
    input  logic   data_valid_i,
    input  logic   accept_i,
    output grant_t grant_o
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved;

    assign starved = inst_valid_i && (starve_cnt_q == CNT_MAX);

    // Data wins unless fetch is pending and has already been passed over STARVE_LIMIT times.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the output unassigned (latch).
        grant_o = '0;
        if (data_valid_i && !starved) begin
            grant_o.data = 1'b1;
        end else if (inst_valid_i) begin
            grant_o.inst = 1'b1;
        end
    end

    // Count data grants taken over a waiting fetch; any other grant restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (accept_i) begin
            if (grant_o.data && inst_valid_i) begin
                if (starve_cnt_q != CNT_MAX) begin
                    starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    // Starve counter register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Sequences instruction fetch and data access onto one SRAM-like bus with a
// single shared translation lookup per accepted request and one transaction
// outstanding. Misaligned data accesses are answered locally with data_ale.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req_valid,
    output logic        inst_req_ready,
    input  logic [31:0] inst_vaddr,
    output logic        inst_resp_valid,
    output logic [31:0] inst_rdata,
    input  logic        data_req_valid,
    output logic        data_req_ready,
    input  logic [31:0] data_vaddr,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_wstrb,
    output logic        data_resp_valid,
    output logic [31:0] data_rdata,
    output logic        data_ale,
    output logic [31:0] trans_vaddr,
    output logic        trans_valid,
    output logic        trans_is_data,
    input  logic [31:0] trans_paddr,
    input  logic        trans_uncached,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_uncached,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    arb_state_e  state_q;
    arb_state_e  state_d;
    grant_t      grant;
    logic        idle;
    logic        accept;
    logic        accept_data;
    logic        accept_store;
    logic        accept_misaligned;

    logic        owner_data_q;
    logic        bus_wr_q;
    logic [1:0]  bus_size_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_wstrb_q;
    logic        bus_uncached_q;
    logic        inst_resp_q;
    logic        data_resp_q;
    logic        data_ale_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;

    mem_req_arbiter_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk          (clk),
        .reset        (reset),
        .inst_valid_i (inst_req_valid),
        .data_valid_i (data_req_valid),
        .accept_i     (accept),
        .grant_o      (grant)
    );

    // Ready is gated by reset as well, so both readies drop the moment reset asserts.
    assign idle              = (state_q == ARB_IDLE) && !reset;
    assign inst_req_ready    = idle && grant.inst;
    assign data_req_ready    = idle && grant.data;
    assign accept_data       = data_req_valid && data_req_ready;
    assign accept            = accept_data || (inst_req_valid && inst_req_ready);
    assign accept_store      = accept_data && data_wr;
    assign accept_misaligned = accept_data && is_misaligned(data_vaddr[1:0], data_size);

    assign trans_valid   = accept;
    assign trans_is_data = grant.data;
    assign trans_vaddr   = grant.data ? data_vaddr : inst_vaddr;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a misaligned access never leaves IDLE; data_ok only counts in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (accept && !accept_misaligned) state_d = ARB_REQ;
            ARB_REQ:  if (bus_addr_ok) state_d = ARB_WAIT;
            ARB_WAIT: if (bus_data_ok) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // FSM outputs: the bus request is held for the whole REQ state.
    always_comb begin
        bus_req = 1'b0;
        if (state_q == ARB_REQ) begin
            bus_req = 1'b1;
        end
    end

    // Capture the translated request on accept; fields stay put until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_data_q   <= 1'b0;
            bus_wr_q       <= 1'b0;
            bus_size_q     <= SIZE_B;
            bus_addr_q     <= '0;
            bus_wdata_q    <= '0;
            bus_wstrb_q    <= '0;
            bus_uncached_q <= 1'b0;
        end else if (accept) begin
            owner_data_q   <= accept_data;
            bus_wr_q       <= accept_store;
            bus_size_q     <= accept_data ? norm_size(data_size) : SIZE_W;
            bus_addr_q     <= trans_paddr;
            bus_wdata_q    <= accept_store ? data_wdata : '0;
            bus_wstrb_q    <= accept_store ? data_wstrb : '0;
            bus_uncached_q <= trans_uncached;
        end
    end

    // Response pulses and read data for the owner of the completed transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_resp_q  <= 1'b0;
            data_resp_q  <= 1'b0;
            data_ale_q   <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            inst_resp_q <= 1'b0;
            data_resp_q <= 1'b0;
            data_ale_q  <= 1'b0;
            if (accept_misaligned) begin
                data_resp_q  <= 1'b1;
                data_ale_q   <= 1'b1;
                data_rdata_q <= '0;
            end else if ((state_q == ARB_WAIT) && bus_data_ok) begin
                if (owner_data_q) begin
                    data_resp_q  <= 1'b1;
                    data_rdata_q <= bus_wr_q ? '0 : bus_rdata;
                end else begin
                    inst_resp_q  <= 1'b1;
                    inst_rdata_q <= bus_rdata;
                end
            end
        end
    end

    assign bus_wr          = bus_wr_q;
    assign bus_size        = bus_size_q;
    assign bus_addr        = bus_addr_q;
    assign bus_wdata       = bus_wdata_q;
    assign bus_wstrb       = bus_wstrb_q;
    assign bus_uncached    = bus_uncached_q;
    assign inst_resp_valid = inst_resp_q;
    assign inst_rdata      = inst_rdata_q;
    assign data_resp_valid = data_resp_q;
    assign data_rdata      = data_rdata_q;
    assign data_ale        = data_ale_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter. Stimulus pushes expected responses into
// a scoreboard queue; a negedge monitor pops and compares each response pulse.
module tb_mem_req_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_vaddr;
    logic        inst_resp_valid;
    logic [31:0] inst_rdata;
    logic        data_req_valid;
    logic        data_req_ready;
    logic [31:0] data_vaddr;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_resp_valid;
    logic [31:0] data_rdata;
    logic        data_ale;
    logic [31:0] trans_vaddr;
    logic        trans_valid;
    logic        trans_is_data;
    logic [31:0] trans_paddr;
    logic        trans_uncached;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_uncached;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    logic [31:0] xlate_mask;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        ale;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        ale;
        logic [1:0]  bus_size;
    } al_vec_t;

    exp_t    sb_q[$];
    exp_t    mon_e;
    al_vec_t al_tab[5];
    logic    exp_is_data[6];
    int      n_checks;
    int      n_errors;

    // Translator model: an XOR remap so a wrong address source is visible.
    assign trans_paddr = trans_vaddr ^ xlate_mask;

    mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_req_valid  (inst_req_valid),
        .inst_req_ready  (inst_req_ready),
        .inst_vaddr      (inst_vaddr),
        .inst_resp_valid (inst_resp_valid),
        .inst_rdata      (inst_rdata),
        .data_req_valid  (data_req_valid),
        .data_req_ready  (data_req_ready),
        .data_vaddr      (data_vaddr),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_wdata      (data_wdata),
        .data_wstrb      (data_wstrb),
        .data_resp_valid (data_resp_valid),
        .data_rdata      (data_rdata),
        .data_ale        (data_ale),
        .trans_vaddr     (trans_vaddr),
        .trans_valid     (trans_valid),
        .trans_is_data   (trans_is_data),
        .trans_paddr     (trans_paddr),
        .trans_uncached  (trans_uncached),
        .bus_req         (bus_req),
        .bus_wr          (bus_wr),
        .bus_size        (bus_size),
        .bus_addr        (bus_addr),
        .bus_wdata       (bus_wdata),
        .bus_wstrb       (bus_wstrb),
        .bus_uncached    (bus_uncached),
        .bus_addr_ok     (bus_addr_ok),
        .bus_data_ok     (bus_data_ok),
        .bus_rdata       (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic is_data, input logic [31:0] rdata, input logic ale);
        exp_t e;
        e.is_data = is_data;
        e.rdata   = rdata;
        e.ale     = ale;
        sb_q.push_back(e);
    endtask

    // Called one cycle after accept (in REQ): addr_ok now, data_ok next cycle.
    // Returns in the cycle where the response pulse is visible.
    task automatic bus_finish(input logic [31:0] rdata);
        bus_addr_ok = 1'b1;
        cyc();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = rdata;
        cyc();
        bus_data_ok = 1'b0;
    endtask

    function automatic logic [31:0] bus_attr();
        return {24'd0, bus_wr, bus_size, bus_wstrb, bus_uncached};
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (inst_resp_valid || data_resp_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: inst_resp=%0b data_resp=%0b with nothing expected",
                         inst_resp_valid, data_resp_valid);
            end else begin
                mon_e = sb_q.pop_front();
                check("resp_owner", 32'(data_resp_valid), 32'(mon_e.is_data));
                check("resp_rdata", mon_e.is_data ? data_rdata : inst_rdata, mon_e.rdata);
                check("resp_ale", 32'(data_ale), 32'(mon_e.ale));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        n_checks = 0;
        n_errors = 0;

        al_tab[0] = '{32'h0000_0201, 2'd1, 1'b1, 2'd0};
        al_tab[1] = '{32'h0000_0202, 2'd1, 1'b0, 2'd1};
        al_tab[2] = '{32'h0000_0203, 2'd0, 1'b0, 2'd0};
        al_tab[3] = '{32'h0000_0302, 2'd3, 1'b1, 2'd0};
        al_tab[4] = '{32'h0000_0304, 2'd3, 1'b0, 2'd2};
        exp_is_data = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        reset          = 1'b1;
        inst_req_valid = 1'b1;
        inst_vaddr     = 32'h1C00_0000;
        data_req_valid = 1'b1;
        data_vaddr     = 32'h0;
        data_wr        = 1'b0;
        data_size      = 2'd2;
        data_wdata     = 32'h0;
        data_wstrb     = 4'h0;
        trans_uncached = 1'b0;
        bus_addr_ok    = 1'b0;
        bus_data_ok    = 1'b0;
        bus_rdata      = 32'h0;
        xlate_mask     = 32'h0;

        // Reset state, with both requesters pushing.
        repeat (3) cyc();
        check("rst_inst_ready", 32'(inst_req_ready), 32'd0);
        check("rst_data_ready", 32'(data_req_ready), 32'd0);
        check("rst_trans_valid", 32'(trans_valid), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_attr", bus_attr(), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_resp", {30'd0, inst_resp_valid, data_resp_valid}, 32'd0);
        check("rst_rdata", inst_rdata | data_rdata | 32'(data_ale), 32'd0);
        inst_req_valid = 1'b0;
        data_req_valid = 1'b0;
        reset = 1'b0;
        cyc();

        // Single fetch, best-case bus timing.
        inst_req_valid = 1'b1;
        inst_vaddr     = 32'h1C00_0000;
        #1;
        check("f1_inst_ready", 32'(inst_req_ready), 32'd1);
        check("f1_trans_valid", 32'(trans_valid), 32'd1);
        check("f1_trans_vaddr", trans_vaddr, 32'h1C00_0000);
        expect_resp(1'b0, 32'h1234_5678, 1'b0);
        cyc();
        inst_req_valid = 1'b0;
        check("f1_bus_req", 32'(bus_req), 32'd1);
        check("f1_bus_addr", bus_addr, 32'h1C00_0000);
        check("f1_bus_attr", bus_attr(), {24'd0, 1'b0, 2'd2, 4'h0, 1'b0});
        bus_addr_ok = 1'b1;
        cyc();
        bus_addr_ok = 1'b0;
        check("f1_wait_no_req", 32'(bus_req), 32'd0);
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h1234_5678;
        cyc();
        bus_data_ok = 1'b0;
        check("f1_resp_t3", 32'(inst_resp_valid), 32'd1);
        cyc();
        check("f1_resp_pulse", 32'(inst_resp_valid), 32'd0);

        // Both requesters held: order D,D,D,D,I,D.
        inst_req_valid = 1'b1;
        inst_vaddr     = 32'h1C00_0004;
        data_req_valid = 1'b1;
        data_vaddr     = 32'h0000_2000;
        data_wr        = 1'b0;
        data_size      = 2'd2;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("starve_is_data", 32'(trans_is_data), 32'(exp_is_data[k]));
            check("starve_data_ready", 32'(data_req_ready), 32'(exp_is_data[k]));
            check("starve_inst_ready", 32'(inst_req_ready), 32'(!exp_is_data[k]));
            rd = exp_is_data[k] ? (32'hD000_0000 + 32'(k)) : (32'h1000_0000 + 32'(k));
            expect_resp(exp_is_data[k], rd, 1'b0);
            cyc();
            bus_finish(rd);
            if (k == 5) begin
                inst_req_valid = 1'b0;
                data_req_valid = 1'b0;
            end
        end
        cyc();

        // Misaligned word store, then an aligned store accepted right away.
        data_req_valid = 1'b1;
        data_wr        = 1'b1;
        data_size      = 2'd2;
        data_vaddr     = 32'h0000_0102;
        data_wdata     = 32'h1111_2222;
        data_wstrb     = 4'hF;
        #1;
        check("mis_ready", 32'(data_req_ready), 32'd1);
        expect_resp(1'b1, 32'h0, 1'b1);
        cyc();
        check("mis_no_bus_req", 32'(bus_req), 32'd0);
        check("mis_resp_t1", 32'(data_resp_valid), 32'd1);
        check("mis_ale_t1", 32'(data_ale), 32'd1);
        data_vaddr = 32'h0000_0104;
        data_wdata = 32'hCAFE_F00D;
        #1;
        check("st_ready_t1", 32'(data_req_ready), 32'd1);
        expect_resp(1'b1, 32'h0, 1'b0);
        cyc();
        data_req_valid = 1'b0;
        check("st_bus_req", 32'(bus_req), 32'd1);
        check("st_bus_addr", bus_addr, 32'h0000_0104);
        check("st_bus_wdata", bus_wdata, 32'hCAFE_F00D);
        check("st_bus_attr", bus_attr(), {24'd0, 1'b1, 2'd2, 4'hF, 1'b0});
        bus_finish(32'hFFFF_FFFF);
        check("st_resp", 32'(data_resp_valid), 32'd1);
        cyc();

        // Alignment boundaries for half/byte/illegal-size loads.
        for (int i = 0; i < 5; i++) begin
            data_req_valid = 1'b1;
            data_wr        = 1'b0;
            data_size      = al_tab[i].size;
            data_vaddr     = al_tab[i].addr;
            #1;
            check("al_ready", 32'(data_req_ready), 32'd1);
            rd = al_tab[i].ale ? 32'h0 : (32'hA000_0000 | 32'(i));
            expect_resp(1'b1, rd, al_tab[i].ale);
            cyc();
            data_req_valid = 1'b0;
            if (al_tab[i].ale) begin
                check("al_mis_no_req", 32'(bus_req), 32'd0);
                check("al_mis_ale", 32'(data_ale), 32'd1);
            end else begin
                check("al_bus_req", 32'(bus_req), 32'd1);
                check("al_bus_size", 32'(bus_size), 32'(al_tab[i].bus_size));
                check("al_bus_addr", bus_addr, al_tab[i].addr);
                bus_finish(rd);
                check("al_resp", 32'(data_resp_valid), 32'd1);
            end
            cyc();
        end

        // addr_ok withheld for 5 cycles with new requests waiting.
        xlate_mask     = 32'h00F0_0000;
        inst_req_valid = 1'b1;
        inst_vaddr     = 32'h1C00_0008;
        #1;
        check("stall_trans_vaddr", trans_vaddr, 32'h1C00_0008);
        expect_resp(1'b0, 32'h7777_8888, 1'b0);
        cyc();
        data_req_valid = 1'b1;
        data_vaddr     = 32'h0000_5000;
        for (int s = 0; s < 5; s++) begin
            inst_vaddr = 32'h2000_0000 + 32'(s * 4);
            #1;
            check("stall_bus_req", 32'(bus_req), 32'd1);
            check("stall_bus_addr", bus_addr, 32'h1CF0_0008);
            check("stall_bus_attr", bus_attr(), {24'd0, 1'b0, 2'd2, 4'h0, 1'b0});
            check("stall_inst_ready", 32'(inst_req_ready), 32'd0);
            check("stall_data_ready", 32'(data_req_ready), 32'd0);
            cyc();
        end
        inst_req_valid = 1'b0;
        data_req_valid = 1'b0;
        bus_finish(32'h7777_8888);
        check("stall_resp", 32'(inst_resp_valid), 32'd1);
        xlate_mask = 32'h0;
        cyc();

        // Uncached load: attribute held for the whole transaction.
        data_req_valid = 1'b1;
        data_wr        = 1'b0;
        data_size      = 2'd2;
        data_vaddr     = 32'h0000_3000;
        trans_uncached = 1'b1;
        expect_resp(1'b1, 32'h0BAD_BEEF, 1'b0);
        cyc();
        data_req_valid = 1'b0;
        trans_uncached = 1'b0;
        check("unc_req", 32'(bus_uncached), 32'd1);
        bus_addr_ok = 1'b1;
        cyc();
        bus_addr_ok = 1'b0;
        check("unc_wait", 32'(bus_uncached), 32'd1);
        bus_data_ok = 1'b1;
        bus_rdata   = 32'h0BAD_BEEF;
        cyc();
        bus_data_ok = 1'b0;
        check("unc_resp", 32'(data_resp_valid), 32'd1);
        cyc();

        // Reset during WAIT of a store; then a fetch and a stale data_ok.
        data_req_valid = 1'b1;
        data_wr        = 1'b1;
        data_vaddr     = 32'h0000_4000;
        data_wdata     = 32'h55AA_55AA;
        data_wstrb     = 4'hF;
        cyc();
        data_req_valid = 1'b0;
        bus_addr_ok    = 1'b1;
        cyc();
        bus_addr_ok    = 1'b0;
        inst_req_valid = 1'b1;
        inst_vaddr     = 32'h1C00_0010;
        reset = 1'b1;
        #1;
        check("rw_inst_ready", 32'(inst_req_ready), 32'd0);
        check("rw_trans_valid", 32'(trans_valid), 32'd0);
        check("rw_bus_addr", bus_addr, 32'd0);
        check("rw_bus_wdata", bus_wdata, 32'd0);
        check("rw_bus_attr", bus_attr(), 32'd0);
        check("rw_rdata", inst_rdata | data_rdata, 32'd0);
        check("rw_resp", {29'd0, inst_resp_valid, data_resp_valid, data_ale}, 32'd0);
        cyc();
        reset       = 1'b0;
        bus_data_ok = 1'b1;
        #1;
        check("rw_first_idle_ready", 32'(inst_req_ready), 32'd1);
        expect_resp(1'b0, 32'h600D_F00D, 1'b0);
        cyc();
        bus_data_ok    = 1'b0;
        inst_req_valid = 1'b0;
        check("rw_no_stale_resp", 32'(data_resp_valid), 32'd0);
        check("rw_bus_req", 32'(bus_req), 32'd1);
        check("rw_bus_addr_new", bus_addr, 32'h1C00_0010);
        bus_finish(32'h600D_F00D);
        check("rw_resp_after", 32'(inst_resp_valid), 32'd1);

        repeat (3) cyc();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Sequences the core's two memory requesters, instruction fetch and data access, onto the single SRAM-like memory bus. It runs one shared address-translation lookup per accepted request and holds exactly one bus transaction outstanding. It sits between the IF/MEM stages and the bus bridge, alongside the address translator. Data accesses have priority, with a bounded-starvation guard for fetch.

## Interface
- STARVE_LIMIT, 4: maximum number of consecutive data grants while fetch is pending; must be ≥ 1.
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- inst_req_valid / inst_req_ready  in / out  1 / 1  fetch request handshake
- inst_vaddr  in  32  fetch virtual address (word-aligned by IF)
- inst_resp_valid  out  1  one-cycle pulse, fetch data returned
- inst_rdata  out  32  fetch data
- data_req_valid / data_req_ready  in / out  1 / 1  data request handshake
- data_vaddr  in  32  data virtual address
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word (3 illegal, treated as word)
- data_wdata  in  32  store data
- data_wstrb  in  4  store byte strobes
- data_resp_valid  out  1  one-cycle pulse, data access complete
- data_rdata  out  32  load data (0 for stores and faults)
- data_ale  out  1  valid with data_resp_valid: misaligned access, no bus issue
- trans_vaddr  out  32  to translator; muxed combinationally from the granted requester
- trans_valid  out  1  a request is being accepted this cycle
- trans_is_data  out  1  1 = data lookup
- trans_paddr  in  32  translator result, combinational in the same cycle
- trans_uncached  in  1  translator result
- bus_req, bus_wr  out  1  SRAM-like request; bus_wr = 1 for a store
- bus_size  out  2  access size
- bus_addr  out  32  physical address
- bus_wdata  out  32  store data
- bus_wstrb  out  4  store strobes
- bus_uncached  out  1  uncached attribute
- bus_addr_ok, bus_data_ok  in  1  bus address/data handshakes
- bus_rdata  in  32  bus read data

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Grant rule: the data request wins if pending, unless starve_cnt == STARVE_LIMIT and a fetch request is pending.
  - Only the granted requester sees ready = 1. Neither ready is asserted outside IDLE.
  - On accept (valid & ready): translation is captured and the request fields are registered into the bus_* outputs.
  - Next state is REQ, except for a misaligned data request.
- Misaligned data request, halfword with addr[0] = 1 or word with addr[1:0] ≠ 0:
  - Accepted normally; no bus request is issued.
  - Next cycle: data_resp_valid = 1, data_ale = 1, data_rdata = 0.
  - FSM stays in IDLE.
- REQ: bus_req = 1 with stable fields until bus_addr_ok. On addr_ok, move to WAIT.
- WAIT:
  - Wait for bus_data_ok; data_ok is sampled only in WAIT.
  - On data_ok, register bus_rdata (stores register 0).
  - The owner's resp_valid pulses the next cycle while the FSM returns to IDLE in that same cycle.
- starve_cnt (width $clog2(STARVE_LIMIT+1)):
  - Increments on each data grant while inst_req_valid = 1.
  - Clears on any fetch grant, and whenever inst_req_valid = 0 during a data grant.
  - Saturates at STARVE_LIMIT.
- Reset: asynchronous, takes effect immediately, including mid-transaction.
  - FSM goes to IDLE; starve_cnt = 0.
  - All outputs go to 0: both ready and resp_valid signals, data_ale, bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb, bus_uncached, both rdata outputs.
  - An in-flight transaction is abandoned; the bus bridge is reset by the same signal.

## Timing
- Best case, accept at cycle T:
  - T+1: bus_req.
  - addr_ok at T+1, data_ok at T+2.
  - T+3: resp_valid, and a new accept is possible in the same cycle.
- Misaligned data: accept at T, data_resp_valid/data_ale at T+1. A new accept is possible at T+1.
- Throughput: at most one transaction in flight; the next accept is no earlier than the resp_valid cycle.
- bus_* fields are stable from entry to REQ until the WAIT exit.
- Simultaneous inst and data requests with starve_cnt < STARVE_LIMIT: data is granted; the fetch request must hold valid.

## Structure
- Shared package, defines.sv:
  - FSM state encoding (`ARB_IDLE`, `ARB_REQ`, `ARB_WAIT`).
  - Size codes (`SIZE_B`, `SIZE_H`, `SIZE_W`).
- One natural sub-module, mem_req_grant:
  - Inputs: both valids and the starve state.
  - Contains the starve counter.
  - Outputs: a one-hot grant.
- The translator stays external and is reached through the trans_* ports.

## Test plan
- Single fetch at 0x1C000000, trans_paddr = 0x1C000000, addr_ok at T+1, data_ok at T+2 with rdata 0x12345678 -> inst_resp_valid at T+3, inst_rdata = 0x12345678.
- Simultaneous fetch and data load, STARVE_LIMIT = 4, both held valid -> grant order D,D,D,D,I,D..., i.e. the 5th grant is the fetch.
- Store, word at 0x00000102 -> no bus_req; data_resp_valid with data_ale = 1 one cycle after accept. Word at 0x00000104 with wstrb 0xF -> bus_wr = 1 and correct bus_wdata/bus_wstrb.
- bus_addr_ok withheld for 5 cycles -> bus_req and all bus_* fields held constant; both ready signals = 0 throughout.
- trans_uncached = 1 on a data load -> bus_uncached = 1 for the whole transaction.
- reset asserted while in WAIT -> all outputs 0 immediately. After release, a fetch is accepted in the first IDLE cycle and a stale data_ok produces no response.
